mem_wb_skid_reg: RTL
====================

# mem_wb_skid_reg

Parametrised MEM/WB pipeline register for the pipelined MIPS core: the next-generation replacement for the fixed 32-bit MEM/WB latch. It adds a valid/ready handshake, an optional 2-entry skid buffer for writeback backpressure, synchronous flush, and a sticky halt flag on syscall in place of simulator termination. It also adds a retired-instruction counter and a pre-muxed writeback/forwarding port. It sits between the MEM stage and register-file writeback.

## Interface
Parameters:
- XLEN, 32, datapath width (ALU result, memory data, PC, instruction)
- REG_W, 5, register-index width
- CNT_W, 32, retired-counter width
- SKID, 1, 1 = two-entry skid buffer; 0 = single register, no skid

Ports:
- clock  in  1  pipeline clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous; drops all held and incoming entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  block accepts an entry on this edge
- in_ins  in  XLEN  instruction word
- in_cs  in  ControlSignal  control bundle (regWrite, memToReg, syscall_sig, ...)
- in_alu_res, in_mem_data, in_pc_plus4  in  XLEN each
- in_write_reg  in  REG_W  destination register
- out_valid  out  1  entry presented to writeback
- out_ready  in  1  writeback consumes the entry
- out_cs  out  ControlSignal
- out_alu_res, out_mem_data, out_pc_plus4  out  XLEN each
- out_write_reg  out  REG_W
- out_func  out  6  funct field (ins[5:0])
- out_is_beq  out  1  opcode (ins[31:26]) == OPC_BEQ
- wb_data  out  XLEN  out_cs.memToReg ? out_mem_data : out_alu_res
- wb_en  out  1  out_valid & out_cs.regWrite & (out_write_reg != 0)
- halted  out  1  sticky; a syscall entry has been accepted
- retired_count  out  CNT_W  completed output handshakes

## Operation
- Accept: in_valid & in_ready. Retire: out_valid & out_ready.
- in_ready = !skid_valid & !halted (SKID=1); = (!main_valid | out_ready) & !halted (SKID=0). Combinational from registered state plus out_ready (SKID=0 only).
- Accepted entry loads main when main is empty or retiring on the same edge; otherwise (SKID=1) it loads skid.
- When main retires and skid is valid, skid moves to main and skid empties; a simultaneous accept then loads skid.
- Order is strictly FIFO; no entry is ever duplicated or lost except by flush.
- flush: main_valid and skid_valid are cleared; a same-edge input is discarded; a same-edge retire still counts. halted is not affected.
- halted sets on the edge that accepts an entry with cs.syscall_sig = 1; that entry is still delivered; further input is refused until reset.
- retired_count increments by 1 per retire and wraps modulo 2^CNT_W.
- out_func, out_is_beq, and wb_data are derived from the main register contents.

## Timing
- Latency: empty block, accept at falling edge N puts the entry on the outputs after edge N; throughput is 1 entry per cycle with out_ready held high.
- Reset values: out_valid 0, all data/cs outputs 0, halted 0, retired_count 0, skid empty; in_ready = 1 after reset deasserts.
- Reset asserted mid-operation empties both entries at once, with no retire counted.
- Full (SKID=1): both entries valid → in_ready 0 until a retire.
- Output data is stable while out_valid & !out_ready.

## Structure
- ControlSignal stays in the shared structures header.
- Add to the shared package: OPC_BEQ = 6'b000100, FUNCT_W = 6, OPC_LSB = 26.
- Natural sub-module: mem_wb_entry_reg, one valid+payload register with a load enable, instantiated for main and (if SKID) skid.

## Test plan
- Reset, then 4 back-to-back entries with ALU results 0x10..0x13 and out_ready=1 → each appears one edge later; retired_count=4; wb_data equals the ALU result when memToReg=0.
- Hold out_ready=0, send 3 entries → first two accepted (main, skid), in_ready=0 on the third; release → outputs 1, 2, then 3, in order.
- memToReg=1, mem_data=0xDEADBEEF, write_reg=0, regWrite=1 → wb_data=0xDEADBEEF, wb_en=0.
- Entry ins=0x10220003 (beq) → out_is_beq=1, out_func=6'h03.
- Full buffer, flush together with in_valid and out_ready → count +1, out_valid=0, input dropped.
- syscall entry accepted → halted=1 and the entry is delivered; next in_valid is refused; reset → halted=0, retired_count=0.

Source files
------------

// File: rtl/mem_wb_skid_reg_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_reg_pkg
// Shared definitions for the MEM/WB stage register of the pipelined MIPS core.
//   ControlSignal : control bundle produced by decode and carried down the pipe
//   OPC_BEQ       : opcode of the beq instruction
//   OPC_W/OPC_LSB : width and position of the opcode field in an instruction
//   FUNCT_W       : width of the funct field (instruction bits [FUNCT_W-1:0])
//   CS_W          : width of the packed ControlSignal bundle
// ---------------------------------------------------------------------------
package mem_wb_skid_reg_pkg;

   typedef struct packed {
      logic       regDst;
      logic       aluSrc;
      logic       memToReg;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       branch;
      logic       jump;
      logic [3:0] aluOp;
      logic       syscall_sig;
   } ControlSignal;

   localparam int          CS_W    = $bits(ControlSignal);
   localparam int          OPC_W   = 6;
   localparam int          OPC_LSB = 26;
   localparam int          FUNCT_W = 6;
   localparam logic [5:0]  OPC_BEQ = 6'b000100;

endpackage

// File: rtl/mem_wb_entry_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_entry_reg
// One valid bit plus a payload word. State changes on the falling clock edge.
//   clock, reset : falling-edge clock, asynchronous active-high reset
//   flush        : clears the valid bit (highest priority)
//   load         : captures d and marks the entry valid
//   clear        : marks the entry empty (ignored when load is also high)
//   d            : payload to capture
//   q_valid, q   : current valid bit and payload
// The payload only changes on load, so it stays stable while held.
// ---------------------------------------------------------------------------
module mem_wb_entry_reg #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         q_valid,
   output logic [W-1:0] q
);

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         q_valid <= 1'b0;
         q       <= '0;
      end else begin
         if (flush)
            q_valid <= 1'b0;
         else if (load)
            q_valid <= 1'b1;
         else if (clear)
            q_valid <= 1'b0;

         if (load && !flush)
            q <= d;
      end
   end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_skid_reg
// MEM/WB pipeline register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush, sticky syscall halt and a retire counter.
// All state updates on the falling edge of clock.
//   clock, reset          : pipeline clock, async active-high reset
//   flush                 : drop held entries and any same-edge input
//   in_valid / in_ready   : MEM-side handshake
//   in_ins, in_cs, in_alu_res, in_mem_data, in_pc_plus4, in_write_reg
//                         : entry payload from MEM
//   out_valid / out_ready : writeback-side handshake
//   out_cs, out_alu_res, out_mem_data, out_pc_plus4, out_write_reg
//                         : payload of the oldest entry (main register)
//   out_func, out_is_beq  : funct field and beq decode of that entry
//   wb_data, wb_en        : pre-muxed writeback / forwarding port
//   halted                : sticky, set when a syscall entry is accepted
//   retired_count         : number of output handshakes, wraps
//
// Handshake: a transfer happens on a falling edge where valid and ready are
// both high; valid never depends on ready, and once out_valid is high the
// presented entry is held unchanged until out_ready takes it.
// ---------------------------------------------------------------------------
module mem_wb_skid_reg
   import mem_wb_skid_reg_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int CNT_W = 32,
   parameter int SKID  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_ins,
   input  ControlSignal     in_cs,
   input  logic [XLEN-1:0]  in_alu_res,
   input  logic [XLEN-1:0]  in_mem_data,
   input  logic [XLEN-1:0]  in_pc_plus4,
   input  logic [REG_W-1:0] in_write_reg,
   output logic             out_valid,
   input  logic             out_ready,
   output ControlSignal     out_cs,
   output logic [XLEN-1:0]  out_alu_res,
   output logic [XLEN-1:0]  out_mem_data,
   output logic [XLEN-1:0]  out_pc_plus4,
   output logic [REG_W-1:0] out_write_reg,
   output logic [5:0]       out_func,
   output logic             out_is_beq,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_en,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count
);

   // Only the opcode and funct fields of the instruction are ever needed
   // downstream, so only those are stored.
   typedef struct packed {
      logic [OPC_W-1:0]   opc;
      logic [FUNCT_W-1:0] funct;
      ControlSignal       cs;
      logic [XLEN-1:0]    alu_res;
      logic [XLEN-1:0]    mem_data;
      logic [XLEN-1:0]    pc_plus4;
      logic [REG_W-1:0]   write_reg;
   } payload_t;

   localparam int PAY_W = $bits(payload_t);

   payload_t           in_pay;
   payload_t           main_pay;
   logic [PAY_W-1:0]   main_d;
   logic [PAY_W-1:0]   main_q;
   logic [PAY_W-1:0]   skid_q;
   logic               main_valid;
   logic               skid_valid;
   logic               accept;
   logic               retire;
   logic               main_free;
   logic               main_load;
   logic               ins_unused;

   assign ins_unused = ^in_ins;

   always_comb begin
      in_pay           = '0;
      in_pay.opc       = in_ins[OPC_LSB +: OPC_W];
      in_pay.funct     = in_ins[FUNCT_W-1:0];
      in_pay.cs        = in_cs;
      in_pay.alu_res   = in_alu_res;
      in_pay.mem_data  = in_mem_data;
      in_pay.pc_plus4  = in_pc_plus4;
      in_pay.write_reg = in_write_reg;
   end

   assign accept    = in_valid & in_ready;
   assign retire    = main_valid & out_ready;
   // Main can take a new entry when it is empty or being drained this edge.
   assign main_free = ~main_valid | retire;

   // The skid entry is always older than the incoming one, so it has
   // priority for the main slot.
   assign main_load = main_free & (skid_valid | accept);
   assign main_d    = skid_valid ? skid_q : in_pay;

   mem_wb_entry_reg #(.W(PAY_W)) u_main (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .load    (main_load),
      .clear   (retire),
      .d       (main_d),
      .q_valid (main_valid),
      .q       (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic skid_load;
         logic skid_clr;

         // in_ready is low whenever skid holds data, so an accept only
         // lands here when main is occupied and not draining.
         assign skid_load = accept & ~main_free;
         assign skid_clr  = main_free & skid_valid;
         // Registered-only ready: no combinational path from out_ready.
         assign in_ready  = ~skid_valid & ~halted;

         mem_wb_entry_reg #(.W(PAY_W)) u_skid (
            .clock   (clock),
            .reset   (reset),
            .flush   (flush),
            .load    (skid_load),
            .clear   (skid_clr),
            .d       (in_pay),
            .q_valid (skid_valid),
            .q       (skid_q)
         );
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_q     = '0;
         assign in_ready   = main_free & ~halted;
      end
   endgenerate

   // A retire on a flush edge has still completed, so it is counted.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         halted        <= 1'b0;
         retired_count <= '0;
      end else begin
         if (accept && in_cs.syscall_sig)
            halted <= 1'b1;
         if (retire)
            retired_count <= retired_count + CNT_W'(1);
      end
   end

   assign main_pay      = payload_t'(main_q);
   assign out_valid     = main_valid;
   assign out_cs        = main_pay.cs;
   assign out_alu_res   = main_pay.alu_res;
   assign out_mem_data  = main_pay.mem_data;
   assign out_pc_plus4  = main_pay.pc_plus4;
   assign out_write_reg = main_pay.write_reg;
   assign out_func      = main_pay.funct;
   assign out_is_beq    = (main_pay.opc == OPC_BEQ);
   assign wb_data       = main_pay.cs.memToReg ? main_pay.mem_data : main_pay.alu_res;
   assign wb_en         = main_valid & main_pay.cs.regWrite & (main_pay.write_reg != '0);

endmodule
